// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latency defaults,
// counter width and FSM state type.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: produces the {hi, lo} pair an op will commit.
// Non-arithmetic ops and divide-by-zero pass the current hi/lo through.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] tmp_hi_o,
    output logic [31:0] tmp_lo_o
);

    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;

    always_comb begin
        prod     = '0;
        a_mag    = '0;
        b_mag    = '0;
        q_mag    = '0;
        r_mag    = '0;
        tmp_hi_o = hi_i;
        tmp_lo_o = lo_i;
        case (op_i)
            MD_MULT: begin
                prod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
                {tmp_hi_o, tmp_lo_o} = prod;
            end
            MD_MULTU: begin
                prod = {32'd0, a_i} * {32'd0, b_i};
                {tmp_hi_o, tmp_lo_o} = prod;
            end
            MD_DIV: begin
                // Divide magnitudes unsigned so 0x80000000 / -1 wraps to 0x80000000 cleanly
                if (b_i != '0) begin
                    a_mag    = a_i[31] ? (32'd0 - a_i) : a_i;
                    b_mag    = b_i[31] ? (32'd0 - b_i) : b_i;
                    q_mag    = a_mag / b_mag;
                    r_mag    = a_mag % b_mag;
                    tmp_lo_o = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
                    tmp_hi_o = a_i[31] ? (32'd0 - r_mag) : r_mag;
                end
            end
            MD_DIVU: begin
                if (b_i != '0) begin
                    tmp_lo_o = a_i / b_i;
                    tmp_hi_o = a_i % b_i;
                end
            end
            default: begin
                tmp_hi_o = hi_i;
                tmp_lo_o = lo_i;
            end
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers for the E stage; results are held in
// temporaries for a fixed latency before committing, with busy/start feeding the hazard unit.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_mdOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] mdRes
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d;
    logic [31:0]      tmp_lo_q, tmp_lo_d;
    logic [31:0]      calc_hi, calc_lo;
    logic             is_div;

    mdu_calc u_calc (
        .op_i     (E_mdOp),
        .a_i      (A),
        .b_i      (B),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .tmp_hi_o (calc_hi),
        .tmp_lo_o (calc_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end

    assign is_div = (E_mdOp == MD_DIV) || (E_mdOp == MD_DIVU);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tmp_hi_d = calc_hi;
                    tmp_lo_d = calc_lo;
                    cnt_d    = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d  = BUSY;
                end else if (E_mdOp == MD_MTHI) begin
                    hi_d = A;
                end else if (E_mdOp == MD_MTLO) begin
                    lo_d = A;
                end
            end
            BUSY: begin
                if (cnt_q <= CNT_W'(1)) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q == BUSY);
        start = !busy && (E_mdOp inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
        case (E_mdOp)
            MD_MFHI: mdRes = hi_q;
            MD_MFLO: mdRes = lo_q;
            default: mdRes = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: a transaction-level model predicts busy/start/mdRes
// per cycle; a monitor on the falling edge pops and compares.
module tb_mdu;

    localparam int unsigned TB_MULT = 5;
    localparam int unsigned TB_DIV  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_mdOp;
    logic [31:0] A, B;
    logic        start, busy;
    logic [31:0] mdRes;

    mdu #(.MULT_CYCLES(TB_MULT), .DIV_CYCLES(TB_DIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .E_mdOp (E_mdOp),
        .A      (A),
        .B      (B),
        .start  (start),
        .busy   (busy),
        .mdRes  (mdRes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        busy;
        logic        start;
        logic [31:0] res;
        bit          has_ref;
        logic [31:0] ref_val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerr    = 0;

    // Model: committed HI/LO, plus one pending result that lands at cycle m_done.
    logic [31:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;
    bit          m_pend = 0;
    int          m_done = 0;
    int          m_cyc  = 0;

    function automatic void model_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] ph, output logic [31:0] pl);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ph = m_hi;
        pl = m_lo;
        case (op)
            4'd1: begin p = sa * sb; ph = p[63:32]; pl = p[31:0]; end
            4'd2: begin up = ua * ub; ph = up[63:32]; pl = up[31:0]; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; pl = q[31:0]; ph = r[31:0]; end
            4'd4: if (b != 0) begin up = ua / ub; pl = up[31:0]; up = ua % ub; ph = up[31:0]; end
            default: ;
        endcase
    endfunction

    task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rst, input bit chk, input bit has_ref,
                         input logic [31:0] refv, input string nm);
        exp_t e;
        logic busy_e, start_e;
        logic [31:0] ph, pl;
        reset  = rst;
        E_mdOp = op;
        A      = a;
        B      = b;
        if (m_pend && m_cyc == m_done) begin
            m_hi   = m_ph;
            m_lo   = m_pl;
            m_pend = 0;
        end
        busy_e  = m_pend;
        start_e = (op >= 4'd1 && op <= 4'd4) && !busy_e;
        e.busy    = busy_e;
        e.start   = start_e;
        e.res     = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        e.has_ref = has_ref;
        e.ref_val = refv;
        e.name    = nm;
        if (chk) exp_q.push_back(e);
        if (rst) begin
            m_hi = '0; m_lo = '0; m_pend = 0;
        end else if (start_e) begin
            model_calc(op, a, b, ph, pl);
            m_ph   = ph;
            m_pl   = pl;
            m_pend = 1;
            m_done = m_cyc + ((op <= 4'd2) ? int'(TB_MULT) : int'(TB_DIV)) + 1;
        end else if (!busy_e) begin
            if (op == 4'd7) m_hi = a;
            if (op == 4'd8) m_lo = a;
        end
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        cycle(op, a, b, 1'b0, 1'b1, 1'b0, 32'd0, "op");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(4'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, "idle");
    endtask

    task automatic rd(input logic [3:0] op, input logic [31:0] refv, input string nm);
        cycle(op, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, refv, nm);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                nchecks++;
                if (busy !== e.busy) begin
                    nerr++;
                    $display("FAIL busy[%s] t=%0t got=%b exp=%b", e.name, $time, busy, e.busy);
                end
                nchecks++;
                if (start !== e.start) begin
                    nerr++;
                    $display("FAIL start[%s] t=%0t got=%b exp=%b", e.name, $time, start, e.start);
                end
                nchecks++;
                if (mdRes !== e.res) begin
                    nerr++;
                    $display("FAIL mdRes[%s] t=%0t got=%h exp=%h", e.name, $time, mdRes, e.res);
                end
                if (e.has_ref) begin
                    nchecks++;
                    if (mdRes !== e.ref_val) begin
                        nerr++;
                        $display("FAIL ref[%s] t=%0t got=%h exp=%h", e.name, $time, mdRes, e.ref_val);
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        logic [3:0] op;
        reset = 1'b1; E_mdOp = '0; A = '0; B = '0;
        @(posedge clk);
        #1;
        cycle(4'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, "rst0");
        cycle(4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, "rst1");
        rd(4'd5, 32'd0, "reset_hi");
        rd(4'd6, 32'd0, "reset_lo");

        step(4'd1, 32'hFFFF_FFFE, 32'd3); idle(5);
        rd(4'd5, 32'hFFFF_FFFF, "mult_hi");
        rd(4'd6, 32'hFFFF_FFFA, "mult_lo");

        step(4'd3, 32'hFFFF_FFF9, 32'd2); idle(10);
        rd(4'd6, 32'hFFFF_FFFD, "div_lo");
        rd(4'd5, 32'hFFFF_FFFF, "div_hi");

        step(4'd4, 32'hFFFF_FFF9, 32'd2); idle(10);
        rd(4'd6, 32'h7FFF_FFFC, "divu_lo");
        rd(4'd5, 32'd1, "divu_hi");

        step(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle(5);
        rd(4'd5, 32'hFFFF_FFFE, "multu_hi");
        rd(4'd6, 32'd1, "multu_lo");

        step(4'd7, 32'h11, 32'd0);
        step(4'd8, 32'h22, 32'd0);
        step(4'd3, 32'h1234, 32'd0); idle(10);
        rd(4'd5, 32'h11, "div0_hi");
        rd(4'd6, 32'h22, "div0_lo");

        step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); idle(10);
        rd(4'd6, 32'h8000_0000, "divovf_lo");
        rd(4'd5, 32'd0, "divovf_hi");

        step(4'd1, 32'h1234, 32'h10);
        step(4'd8, 32'h55, 32'd0);
        step(4'd1, 32'd7, 32'd7);
        idle(3);
        rd(4'd6, 32'h12340, "busy_ign_lo");

        step(4'd1, 32'd3, 32'd4); idle(5);
        step(4'd1, 32'd5, 32'd6); idle(5);
        rd(4'd6, 32'd30, "b2b_lo");

        step(4'd7, 32'hAB, 32'd0);
        rd(4'd5, 32'hAB, "mthi_fwd");

        step(4'd3, 32'd100, 32'd7); idle(2);
        cycle(4'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, "midrst");
        rd(4'd5, 32'd0, "midrst_hi");
        rd(4'd6, 32'd0, "midrst_lo");
        idle(12);
        rd(4'd6, 32'd0, "nolate_lo");
        rd(4'd5, 32'd0, "nolate_hi");

        for (int i = 0; i < 600; i++) begin
            op = 4'($urandom_range(0, 15));
            cycle(op, rnd_word(), rnd_word(), ($urandom_range(0, 99) == 0), 1'b1, 1'b0, 32'd0, "rand");
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() > 0) begin
            nchecks++;
            nerr++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
